toy_vmtx_load: RTL and testbench

TOY_VMTX_LOAD -- requirements
Module: toy_vmtx_load

---
 rtl/toy_vmtx_load.sv | 163 ++++++++++++++++
 tb/tb_toy_vmtx_load.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toy_vmtx_load.sv
// Strided vector load: fetches ELEM_NUM elements from shared memory into one VRF register.
// Optional TOY_VMTX_LOAD_ERR_EN adds err_vld/err_opc reporting of non-load opcodes.
//
// state | meaning
// IDLE  | ready for an instruction
// RUN   | issuing reads and writing responses into the VRF
// DONE  | one-cycle completion, last VRF write visible

module toy_vmtx_load #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ELEM_NUM      = 4,
    parameter int REG_IDX_WIDTH = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        instr_vld,
    output logic                        instr_rdy,
    input  logic [4:0]                  instr_opc,
    input  logic [REG_IDX_WIDTH-1:0]    instr_rd,
    input  logic [ADDR_WIDTH-1:0]       instr_base,
    input  logic [ADDR_WIDTH-1:0]       instr_stride,
    output logic                        mem_req_vld,
    input  logic                        mem_req_rdy,
    output logic [ADDR_WIDTH-1:0]       mem_req_addr,
    input  logic                        mem_rsp_vld,
    input  logic [DATA_WIDTH-1:0]       mem_rsp_data,
    output logic                        vrf_wr_en,
    output logic [REG_IDX_WIDTH-1:0]    vrf_wr_idx,
    output logic [$clog2(ELEM_NUM)-1:0] vrf_wr_elem,
    output logic [DATA_WIDTH-1:0]       vrf_wr_data,
    output logic                        done_vld,
    output logic [REG_IDX_WIDTH-1:0]    done_rd,
`ifdef TOY_VMTX_LOAD_ERR_EN
    output logic                        err_vld,
    output logic [4:0]                  err_opc,
`endif
    output logic                        busy
);

    localparam int ELEM_W = $clog2(ELEM_NUM);
    localparam int CNT_W  = ELEM_W + 1;
    localparam logic [4:0]       OPC_MTX_LOAD = 5'b00001;
    localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(ELEM_NUM);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(ELEM_NUM - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [REG_IDX_WIDTH-1:0] rd_q;
    logic [ADDR_WIDTH-1:0]    stride_q;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [CNT_W-1:0]         req_cnt_q;
    logic [CNT_W-1:0]         rsp_cnt_q;
    logic                     wr_en_q;
    logic [ELEM_W-1:0]        wr_elem_q;
    logic [DATA_WIDTH-1:0]    wr_data_q;

    logic accept;
    logic load_go;
    logic req_fire;
    logic rsp_take;

    assign instr_rdy = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign accept    = instr_vld & instr_rdy;
    assign load_go   = accept & (instr_opc == OPC_MTX_LOAD);

    assign mem_req_vld  = (state_q == S_RUN) && (req_cnt_q < CNT_FULL);
    assign mem_req_addr = addr_q;
    assign req_fire     = mem_req_vld & mem_req_rdy;
    assign rsp_take     = (state_q == S_RUN) && mem_rsp_vld && (rsp_cnt_q < CNT_FULL);

    assign vrf_wr_en   = wr_en_q;
    assign vrf_wr_idx  = rd_q;
    assign vrf_wr_elem = wr_elem_q;
    assign vrf_wr_data = wr_data_q;
    assign done_vld    = (state_q == S_DONE);
    assign done_rd     = rd_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (load_go) state_d = S_RUN;
            S_RUN:   if (rsp_take && (rsp_cnt_q == CNT_LAST)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Address advances by stride on each accepted request; wrap-around is intended.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q      <= '0;
            stride_q  <= '0;
            addr_q    <= '0;
            req_cnt_q <= '0;
            rsp_cnt_q <= '0;
        end else if (load_go) begin
            rd_q      <= instr_rd;
            stride_q  <= instr_stride;
            addr_q    <= instr_base;
            req_cnt_q <= '0;
            rsp_cnt_q <= '0;
        end else begin
            if (req_fire) begin
                addr_q    <= addr_q + stride_q;
                req_cnt_q <= req_cnt_q + 1'b1;
            end
            if (rsp_take) begin
                rsp_cnt_q <= rsp_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_elem_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= rsp_take;
            if (rsp_take) begin
                wr_elem_q <= rsp_cnt_q[ELEM_W-1:0];
                wr_data_q <= mem_rsp_data;
            end
        end
    end

`ifdef TOY_VMTX_LOAD_ERR_EN
    logic       err_vld_q;
    logic [4:0] err_opc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_vld_q <= 1'b0;
            err_opc_q <= '0;
        end else begin
            err_vld_q <= accept && (instr_opc != OPC_MTX_LOAD);
            if (accept && (instr_opc != OPC_MTX_LOAD)) begin
                err_opc_q <= instr_opc;
            end
        end
    end

    assign err_vld = err_vld_q;
    assign err_opc = err_opc_q;
`endif

endmodule

// File: tb/tb_toy_vmtx_load.sv
// Self-checking bench for toy_vmtx_load: directed and randomized strided loads against a queue-based memory model.
// Build with TOY_VMTX_LOAD_ERR_EN to also exercise the illegal-opcode error outputs.

module tb_toy_vmtx_load;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_vld;
    logic        instr_rdy;
    logic [4:0]  instr_opc;
    logic [4:0]  instr_rd;
    logic [31:0] instr_base;
    logic [31:0] instr_stride;
    logic        mem_req_vld;
    logic        mem_req_rdy;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_vld;
    logic [31:0] mem_rsp_data;
    logic        vrf_wr_en;
    logic [4:0]  vrf_wr_idx;
    logic [1:0]  vrf_wr_elem;
    logic [31:0] vrf_wr_data;
    logic        done_vld;
    logic [4:0]  done_rd;
    logic        busy;
`ifdef TOY_VMTX_LOAD_ERR_EN
    logic        err_vld;
    logic [4:0]  err_opc;
`endif

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    toy_vmtx_load dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_vld    (instr_vld),
        .instr_rdy    (instr_rdy),
        .instr_opc    (instr_opc),
        .instr_rd     (instr_rd),
        .instr_base   (instr_base),
        .instr_stride (instr_stride),
        .mem_req_vld  (mem_req_vld),
        .mem_req_rdy  (mem_req_rdy),
        .mem_req_addr (mem_req_addr),
        .mem_rsp_vld  (mem_rsp_vld),
        .mem_rsp_data (mem_rsp_data),
        .vrf_wr_en    (vrf_wr_en),
        .vrf_wr_idx   (vrf_wr_idx),
        .vrf_wr_elem  (vrf_wr_elem),
        .vrf_wr_data  (vrf_wr_data),
        .done_vld     (done_vld),
        .done_rd      (done_rd),
`ifdef TOY_VMTX_LOAD_ERR_EN
        .err_vld      (err_vld),
        .err_opc      (err_opc),
`endif
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one MTX_LOAD. mode: 0 always ready, 1 random ready, 2 ready low 3 cycles at second request.
    // Memory answers in order, latency 1..lat_max cycles after each accepted request.
    task automatic do_load(input logic [4:0] rd, input logic [31:0] base, input logic [31:0] stride,
                           input int mode, input int lat_max, input int abort_after,
                           input bit hold_next, output int done_cyc);
        int          t_q[$];
        logic [31:0] d_q[$];
        logic [31:0] exp_data[$];
        int          req_i = 0;
        int          wr_i = 0;
        int          last_t = 0;
        int          bp_left = 3;
        bit          wr_pend = 0;
        bit          done_seen = 0;
        bit          last_wr;
        bit          rdy;
        int          lat;
        int          t;
        logic [31:0] ea;

        done_cyc = -1;
        @(negedge clk);
        chk("accept_rdy", instr_rdy, 1);
        instr_vld    = 1;
        instr_opc    = 5'b00001;
        instr_rd     = rd;
        instr_base   = base;
        instr_stride = stride;
        mem_req_rdy  = 0;
        mem_rsp_vld  = 0;

        for (int k = 1; k <= 300 && !done_seen; k++) begin
            @(negedge clk);
            instr_vld = 0;
            chk("busy_run", busy, 1);
            chk("instr_rdy_run", instr_rdy, 0);
            chk("req_vld", mem_req_vld, (req_i < N));
            if (mem_req_vld) begin
                ea = base + 32'(req_i) * stride;
                chk("req_addr", mem_req_addr, ea);
            end
            last_wr = wr_pend && (wr_i == N - 1);
            chk("wr_en", vrf_wr_en, wr_pend);
            if (vrf_wr_en && wr_pend) begin
                chk("wr_idx", vrf_wr_idx, rd);
                chk("wr_elem", vrf_wr_elem, wr_i);
                chk("wr_data", vrf_wr_data, exp_data[wr_i]);
                wr_i++;
            end
            chk("done_vld", done_vld, last_wr);
            if (done_vld) begin
                chk("done_rd", done_rd, rd);
                done_seen = 1;
                done_cyc  = k;
            end
            wr_pend = 0;
            if (abort_after > 0 && wr_i == abort_after) break;

            if (done_seen) begin
                mem_rsp_vld = 0;
                mem_req_rdy = 1'($urandom_range(0, 1));
                if (hold_next) begin
                    instr_vld = 1;
                    instr_opc = 5'b00001;
                end
            end else begin
                case (mode)
                    0: rdy = 1;
                    1: rdy = ($urandom_range(0, 3) != 0);
                    default: begin
                        if (req_i == 1 && bp_left > 0) begin
                            rdy = 0;
                            bp_left--;
                        end else begin
                            rdy = 1;
                        end
                    end
                endcase
                mem_req_rdy = rdy;
                if (mem_req_vld && rdy && req_i < N) begin
                    lat = (lat_max <= 1) ? 1 : int'($urandom_range(1, lat_max));
                    t = (k + lat > last_t + 1) ? k + lat : last_t + 1;
                    t_q.push_back(t);
                    d_q.push_back($urandom);
                    last_t = t;
                    req_i++;
                end
                mem_rsp_vld = 0;
                if (t_q.size() > 0 && t_q[0] == k) begin
                    mem_rsp_vld  = 1;
                    mem_rsp_data = d_q[0];
                    exp_data.push_back(d_q[0]);
                    void'(t_q.pop_front());
                    void'(d_q.pop_front());
                    wr_pend = 1;
                end
            end
        end
        if (abort_after == 0) begin
            chk("done_seen", done_seen, 1);
            chk("write_count", wr_i, N);
        end
    endtask

    task automatic do_illegal(input logic [4:0] opc);
        @(negedge clk);
        chk("ill_rdy_before", instr_rdy, 1);
        instr_vld    = 1;
        instr_opc    = opc;
        instr_rd     = 5'($urandom);
        instr_base   = $urandom;
        instr_stride = $urandom;
        @(negedge clk);
        instr_vld = 0;
        chk("ill_rdy_after", instr_rdy, 1);
        chk("ill_busy", busy, 0);
        chk("ill_req_vld", mem_req_vld, 0);
`ifdef TOY_VMTX_LOAD_ERR_EN
        chk("ill_err_vld", err_vld, 1);
        chk("ill_err_opc", err_opc, opc);
`endif
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("ill_quiet_req", mem_req_vld, 0);
            chk("ill_quiet_wr", vrf_wr_en, 0);
            chk("ill_quiet_done", done_vld, 0);
`ifdef TOY_VMTX_LOAD_ERR_EN
            chk("ill_err_pulse", err_vld, 0);
`endif
        end
    endtask

    initial begin
        int dc;
        logic [4:0] opc;

        rst_n        = 0;
        instr_vld    = 0;
        instr_opc    = 0;
        instr_rd     = 0;
        instr_base   = 0;
        instr_stride = 0;
        mem_req_rdy  = 0;
        mem_rsp_vld  = 0;
        mem_rsp_data = 0;
        repeat (2) @(negedge clk);
        chk("rst_instr_rdy", instr_rdy, 1);
        chk("rst_busy", busy, 0);
        chk("rst_req_vld", mem_req_vld, 0);
        chk("rst_wr_en", vrf_wr_en, 0);
        chk("rst_done", done_vld, 0);
`ifdef TOY_VMTX_LOAD_ERR_EN
        chk("rst_err_vld", err_vld, 0);
        chk("rst_err_opc", err_opc, 0);
`endif
        rst_n = 1;

        // Basic load: done six cycles after acceptance.
        do_load(5'd3, 32'h100, 32'd4, 0, 1, 0, 0, dc);
        chk("case1_done_cycle", dc, 6);

        // Backpressure on the second request.
        do_load(5'd7, 32'h2000, 32'd16, 2, 1, 0, 0, dc);
        chk("case2_done_cycle", dc, 9);

        // Address wrap.
        do_load(5'd12, 32'hFFFF_FFF8, 32'd4, 0, 1, 0, 0, dc);

        // Illegal opcodes: MTX_MUL and a few random non-load values.
        do_illegal(5'd0);
        for (int i = 0; i < 3; i++) begin
            opc = 5'($urandom_range(2, 31));
            do_illegal(opc);
        end

        // Reset in mid-load, then stray responses.
        do_load(5'd9, 32'h400, 32'd8, 0, 1, 2, 0, dc);
        rst_n        = 0;
        mem_req_rdy  = 1;
        mem_rsp_vld  = 1;
        mem_rsp_data = $urandom;
        @(negedge clk);
        rst_n = 1;
        chk("abort_instr_rdy", instr_rdy, 1);
        chk("abort_busy", busy, 0);
        chk("abort_req_vld", mem_req_vld, 0);
        chk("abort_wr_en", vrf_wr_en, 0);
        chk("abort_done", done_vld, 0);
        for (int i = 0; i < 2; i++) begin
            mem_rsp_vld  = 1;
            mem_rsp_data = $urandom;
            @(negedge clk);
            chk("stray_wr_en", vrf_wr_en, 0);
            chk("stray_done", done_vld, 0);
            chk("stray_req_vld", mem_req_vld, 0);
        end
        mem_rsp_vld = 0;
        @(negedge clk);
        chk("stray_tail_wr_en", vrf_wr_en, 0);

        // Randomized loads, chained so the next instruction is offered during DONE.
        for (int i = 0; i < 12; i++) begin
            do_load(5'($urandom), $urandom, $urandom, 1, 3, 0, (i != 11), dc);
        end

        @(negedge clk);
        instr_vld = 0;
        chk("end_idle", instr_rdy, 1);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
